muldiv_sequencer: RTL



---
 rtl/muldiv_pkg.sv | 21 ++
 rtl/muldiv_step.sv | 36 +++
 rtl/muldiv_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings and sizing for the iterative multiply/divide sequencer.
package muldiv_pkg;

  localparam int STEPS = 32;
  // One extra bit so the counter can hold STEPS itself when early-out needs it.
  localparam int CNT_W = $clog2(STEPS) + 1;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIXUP
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift/add multiply (mode=0) or restoring divide (mode=1).
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] operand,
  input  logic             mode,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
    // Remainder is kept below the divisor, so the shifted value needs one extra bit.
    shifted = {hi, lo[WIDTH-1]};
    diff    = shifted[WIDTH-1:0] - operand;
    if (mode) begin
      if (shifted >= {1'b0, operand}) begin
        hi_next = diff;
        lo_next = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_next = shifted[WIDTH-1:0];
        lo_next = {lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_next = sum[WIDTH:1];
      lo_next = {sum[0], lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO, with MTHI/MTLO and EX stall.
// Optional MULDIV_EARLY_OUT_EN: multiplies finish once the remaining multiplier bits are zero.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] Operand_A,
  input  logic [WIDTH-1:0] Operand_B,
  input  logic             Read_Req,
  input  logic             Hi_We,
  input  logic             Lo_We,
  input  logic [WIDTH-1:0] Wr_Data,
  output logic             Busy,
  output logic             Stall,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  state_e             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               is_div_reg, neg_res_reg, neg_rem_reg, busy_reg, done_reg;
  logic [WIDTH-1:0]   acc_reg, low_reg, opd_reg, hi_reg, lo_reg;
  logic [WIDTH-1:0]   step_hi, step_lo;
  logic               is_signed, a_neg, b_neg, last_step;
  logic [WIDTH-1:0]   mag_a, mag_b, hi_fix, lo_fix;
  logic [2*WIDTH-1:0] prod, prod_signed;

  assign is_signed = (Op == OP_MULT) || (Op == OP_DIV);
  assign a_neg     = is_signed & Operand_A[WIDTH-1];
  assign b_neg     = is_signed & Operand_B[WIDTH-1];
  assign mag_a     = a_neg ? -Operand_A : Operand_A;
  assign mag_b     = b_neg ? -Operand_B : Operand_B;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .hi      (acc_reg),
    .lo      (low_reg),
    .operand (opd_reg),
    .mode    (is_div_reg),
    .hi_next (step_hi),
    .lo_next (step_lo)
  );

`ifdef MULDIV_EARLY_OUT_EN
  // low_reg[31-cnt:0] is the unconsumed multiplier; bit 0 is consumed this cycle.
  assign last_step = (cnt_reg == CNT_W'(STEPS - 1)) ||
                     (!is_div_reg && (((low_reg & ({WIDTH{1'b1}} >> cnt_reg)) >> 1) == '0));
  // Skipped iterations would only have shifted right, so apply them at once.
  assign prod = {acc_reg, low_reg} >> (CNT_W'(STEPS) - cnt_reg);
`else
  assign last_step = (cnt_reg == CNT_W'(STEPS - 1));
  assign prod      = {acc_reg, low_reg};
`endif

  always_comb begin
    prod_signed = neg_res_reg ? -prod : prod;
    if (is_div_reg) begin
      hi_fix = neg_rem_reg ? -acc_reg : acc_reg;
      lo_fix = neg_res_reg ? -low_reg : low_reg;
    end else begin
      hi_fix = prod_signed[2*WIDTH-1:WIDTH];
      lo_fix = prod_signed[WIDTH-1:0];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      is_div_reg  <= 1'b0;
      neg_res_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      acc_reg     <= '0;
      low_reg     <= '0;
      opd_reg     <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (Hi_We) hi_reg <= Wr_Data;
          if (Lo_We) lo_reg <= Wr_Data;
          if (Start) begin
            is_div_reg  <= Op[1];
            acc_reg     <= '0;
            low_reg     <= Op[1] ? mag_a : mag_b;
            opd_reg     <= Op[1] ? mag_b : mag_a;
            // Divide by zero keeps LO all ones and HI equal to the dividend.
            neg_res_reg <= (a_neg ^ b_neg) & ~(Op[1] & (Operand_B == '0));
            neg_rem_reg <= a_neg;
            cnt_reg     <= '0;
            busy_reg    <= 1'b1;
            state_reg   <= S_RUN;
          end
        end
        S_RUN: begin
          acc_reg <= step_hi;
          low_reg <= step_lo;
          cnt_reg <= cnt_reg + 1'b1;
          if (last_step) state_reg <= S_FIXUP;
        end
        S_FIXUP: begin
          hi_reg    <= hi_fix;
          lo_reg    <= lo_fix;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign Busy  = busy_reg;
  assign Done  = done_reg;
  assign Hi    = hi_reg;
  assign Lo    = lo_reg;
  assign Stall = busy_reg & (Start | Read_Req | Hi_We | Lo_We);

endmodule
